bpu_update_ctrl: RTL and testbench

Resolution/update controller for the branch prediction unit. It accepts resolved-branch records from the execute stage, detects mispredictions and issues a one-cycle flush with the correct fetch address. Records are buffered and drained one per cycle into the predictor's update port (BHT strobe, taken flag, exec PC, target, BTB way). It also keeps saturating branch and mispredict statistics for the performance counters.

---
 rtl/bpu_pkg.sv | 22 ++
 rtl/bpu_res_fifo.sv | 59 +++++
 rtl/bpu_update_ctrl.sv | 161 ++++++++++++++++
 tb/tb_bpu_update_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bpu_pkg.sv
// Shared types and constants for the branch resolution/update path.
// Declarations only; no state, no latency, no flow control.
package bpu_pkg;

    localparam int BPU_INSTR_BYTES = 4;
    localparam int BPU_MAX_ADDR_W  = 64;
    localparam int BPU_WAY_W       = 2;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } bpu_ctrl_state_e;

    // Only the fields the predictor update needs; pred_* are consumed at accept time.
    typedef struct packed {
        logic [BPU_MAX_ADDR_W-1:0] pc;
        logic [BPU_MAX_ADDR_W-1:0] target;
        logic                      taken;
        logic [BPU_WAY_W-1:0]      way;
    } res_rec_t;

endpackage

// File: rtl/bpu_res_fifo.sv
// Resolved-record buffer: power-of-two depth FIFO with same-cycle push and pop.
// Latency: a push is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module bpu_res_fifo
    import bpu_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic     i_clk,
    input  logic     i_arst,
    input  logic     i_push_vld,
    input  res_rec_t i_push_dat,
    input  logic     i_pop_rdy,
    output res_rec_t o_head_dat,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    res_rec_t           mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push, pop;

    assign o_full     = (count_q == CNT_W'(DEPTH));
    assign o_empty    = (count_q == '0);
    assign o_head_dat = mem_q[rd_ptr_q];

    always_comb begin
        push     = i_push_vld && !o_full;
        pop      = i_pop_rdy && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= i_push_dat;
    end

endmodule

// File: rtl/bpu_update_ctrl.sv
// Branch resolution controller: mispredict flush/redirect, buffered predictor updates, stats.
// Latency: flush one cycle after accept; update strobe one cycle after the record's pop (2 edges min).
// Backpressure: ready drops when the buffer is full or for FLUSH_CYCLES after a mispredict; i_bpu_hold stalls draining.
module bpu_update_ctrl
    import bpu_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int FIFO_DEPTH   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
)(
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_res_valid,
    output logic                  o_res_ready,
    input  logic [ADDR_WIDTH-1:0] i_res_pc,
    input  logic [ADDR_WIDTH-1:0] i_res_target,
    input  logic                  i_res_taken,
    input  logic                  i_res_pred_taken,
    input  logic [ADDR_WIDTH-1:0] i_res_pred_target,
    input  logic [1:0]            i_res_way,
    input  logic                  i_bpu_hold,
    output logic                  o_flush,
    output logic [ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                  o_bpu_branch_instr,
    output logic                  o_bpu_branch_taken,
    output logic [ADDR_WIDTH-1:0] o_bpu_pc_exec,
    output logic [ADDR_WIDTH-1:0] o_bpu_target_exec,
    output logic [1:0]            o_bpu_way_write,
    output logic [CNT_WIDTH-1:0]  o_branch_cnt,
    output logic [CNT_WIDTH-1:0]  o_mispred_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    bpu_ctrl_state_e       state_q, state_d;
    logic [FC_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                  flush_q, flush_d;
    logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
    logic                  upd_vld_q, upd_vld_d;
    logic                  upd_taken_q, upd_taken_d;
    logic [ADDR_WIDTH-1:0] upd_pc_q, upd_pc_d;
    logic [ADDR_WIDTH-1:0] upd_target_q, upd_target_d;
    logic [1:0]            upd_way_q, upd_way_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  mispred_cnt_q, mispred_cnt_d;

    logic                  res_acc, rec_mispred, drain_pop;
    logic                  fifo_full, fifo_empty;
    logic [ADDR_WIDTH-1:0] redirect_calc;
    res_rec_t              push_dat, head_dat;

    assign o_res_ready = !fifo_full && (state_q == RUN);

    always_comb begin
        push_dat.pc     = BPU_MAX_ADDR_W'(i_res_pc);
        push_dat.target = BPU_MAX_ADDR_W'(i_res_target);
        push_dat.taken  = i_res_taken;
        push_dat.way    = i_res_way;
    end

    bpu_res_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_arst     (i_arst),
        .i_push_vld (res_acc),
        .i_push_dat (push_dat),
        .i_pop_rdy  (drain_pop),
        .o_head_dat (head_dat),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    always_comb begin
        res_acc     = i_res_valid && o_res_ready;
        rec_mispred = (i_res_taken != i_res_pred_taken) ||
                      (i_res_taken && i_res_pred_taken && (i_res_target != i_res_pred_target));
        redirect_calc = i_res_taken ? i_res_target
                                    : i_res_pc + ADDR_WIDTH'(BPU_INSTR_BYTES);
        drain_pop   = !fifo_empty && !i_bpu_hold;

        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        // Loading FLUSH_CYCLES-1 and leaving on zero keeps ready low for exactly FLUSH_CYCLES cycles.
        case (state_q)
            RUN: begin
                if (res_acc && rec_mispred) begin
                    state_d     = FLUSH;
                    flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) state_d = RUN;
                else                   flush_cnt_d = flush_cnt_q - FC_W'(1);
            end
            default: state_d = RUN;
        endcase

        flush_d    = res_acc && rec_mispred;
        redirect_d = flush_d ? redirect_calc : redirect_q;

        upd_vld_d    = drain_pop;
        upd_taken_d  = upd_taken_q;
        upd_pc_d     = upd_pc_q;
        upd_target_d = upd_target_q;
        upd_way_d    = upd_way_q;
        if (drain_pop) begin
            upd_taken_d  = head_dat.taken;
            upd_pc_d     = head_dat.pc[ADDR_WIDTH-1:0];
            upd_target_d = head_dat.target[ADDR_WIDTH-1:0];
            upd_way_d    = head_dat.way;
        end

        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res_acc && (branch_cnt_q != '1))
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
        if (res_acc && rec_mispred && (mispred_cnt_q != '1))
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q       <= RUN;
            flush_cnt_q   <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            upd_vld_q     <= 1'b0;
            upd_taken_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_way_q     <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            upd_vld_q     <= upd_vld_d;
            upd_taken_q   <= upd_taken_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_way_q     <= upd_way_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign o_flush            = flush_q;
    assign o_redirect_pc      = redirect_q;
    assign o_bpu_branch_instr = upd_vld_q;
    assign o_bpu_branch_taken = upd_taken_q;
    assign o_bpu_pc_exec      = upd_pc_q;
    assign o_bpu_target_exec  = upd_target_q;
    assign o_bpu_way_write    = upd_way_q;
    assign o_branch_cnt       = branch_cnt_q;
    assign o_mispred_cnt      = mispred_cnt_q;

endmodule

// File: tb/tb_bpu_update_ctrl.sv
// Bench for bpu_update_ctrl: directed scenarios plus a randomized run against a queue-based model.
module tb_bpu_update_ctrl;

    localparam int DEPTH = 2;
    localparam int FC    = 2;

    logic        clk = 1'b0;
    logic        arst;
    logic        res_valid, res_taken, res_ptaken, bpu_hold;
    logic [63:0] res_pc, res_tgt, res_ptgt;
    logic [1:0]  res_way;

    logic        ready, flush, strobe, taken_o;
    logic [63:0] redirect, pc_o, tgt_o;
    logic [1:0]  way_o;
    logic [31:0] bcnt, mcnt;

    logic        s_ready, s_flush, s_strobe, s_taken_o;
    logic [63:0] s_redirect, s_pc_o, s_tgt_o;
    logic [1:0]  s_way_o;
    logic [3:0]  s_bcnt, s_mcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bpu_update_ctrl dut (
        .i_clk(clk), .i_arst(arst), .i_res_valid(res_valid), .o_res_ready(ready),
        .i_res_pc(res_pc), .i_res_target(res_tgt), .i_res_taken(res_taken),
        .i_res_pred_taken(res_ptaken), .i_res_pred_target(res_ptgt), .i_res_way(res_way),
        .i_bpu_hold(bpu_hold), .o_flush(flush), .o_redirect_pc(redirect),
        .o_bpu_branch_instr(strobe), .o_bpu_branch_taken(taken_o), .o_bpu_pc_exec(pc_o),
        .o_bpu_target_exec(tgt_o), .o_bpu_way_write(way_o),
        .o_branch_cnt(bcnt), .o_mispred_cnt(mcnt)
    );

    bpu_update_ctrl #(.CNT_WIDTH(4)) dut_small (
        .i_clk(clk), .i_arst(arst), .i_res_valid(res_valid), .o_res_ready(s_ready),
        .i_res_pc(res_pc), .i_res_target(res_tgt), .i_res_taken(res_taken),
        .i_res_pred_taken(res_ptaken), .i_res_pred_target(res_ptgt), .i_res_way(res_way),
        .i_bpu_hold(bpu_hold), .o_flush(s_flush), .o_redirect_pc(s_redirect),
        .o_bpu_branch_instr(s_strobe), .o_bpu_branch_taken(s_taken_o), .o_bpu_pc_exec(s_pc_o),
        .o_bpu_target_exec(s_tgt_o), .o_bpu_way_write(s_way_o),
        .o_branch_cnt(s_bcnt), .o_mispred_cnt(s_mcnt)
    );

    // Reference model: pending updates as a queue, flush as a count of blocked cycles.
    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        tk;
        logic [1:0]  way;
    } mrec_t;

    mrec_t       mq[$];
    mrec_t       m_upd, m_tmp;
    int          m_block;
    logic        m_flush, m_strobe, m_acc, m_mis;
    logic [63:0] m_redirect;
    logic [31:0] m_bcnt, m_mcnt;
    logic [3:0]  m_sb, m_sm;

    function automatic logic m_ready();
        return (mq.size() < DEPTH) && (m_block == 0);
    endfunction

    always @(posedge clk or negedge arst) begin
        if (!arst) begin
            mq.delete();
            m_upd = '0; m_block = 0; m_flush = 0; m_strobe = 0; m_redirect = '0;
            m_bcnt = '0; m_mcnt = '0; m_sb = '0; m_sm = '0;
        end else begin
            m_acc = res_valid && m_ready();
            m_mis = res_taken ? (!res_ptaken || res_tgt != res_ptgt) : res_ptaken;
            m_strobe = 0;
            if (mq.size() > 0 && !bpu_hold) begin
                m_upd    = mq.pop_front();
                m_strobe = 1;
            end
            m_flush = m_acc && m_mis;
            if (m_flush) m_redirect = res_taken ? res_tgt : res_pc + 64'd4;
            if (m_flush) m_block = FC;
            else if (m_block > 0) m_block--;
            if (m_acc) begin
                m_tmp.pc = res_pc; m_tmp.tgt = res_tgt; m_tmp.tk = res_taken; m_tmp.way = res_way;
                mq.push_back(m_tmp);
                if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
                if (m_sb != 4'hF) m_sb++;
                if (m_mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt++;
                if (m_mis && m_sm != 4'hF) m_sm++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc, input logic [63:0] tgt,
                         input logic tk, input logic ptk, input logic [63:0] ptgt,
                         input logic [1:0] way);
        res_valid = v; res_pc = pc; res_tgt = tgt; res_taken = tk;
        res_ptaken = ptk; res_ptgt = ptgt; res_way = way;
    endtask

    task automatic do_reset();
        arst = 0; res_valid = 0; bpu_hold = 0;
        tick(); tick();
        arst = 1;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({flush, redirect, strobe, taken_o, pc_o, tgt_o, way_o, bcnt, mcnt, s_bcnt, s_mcnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flush=%b strobe=%b pc=%h bcnt=%0d mcnt=%0d want all 0", flush, strobe, pc_o, bcnt, mcnt);
        end
        arst = 1;
        tick();
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    endtask

    task automatic test_correct();
        do_reset();
        drive(1, 64'h100, 64'h200, 1, 1, 64'h200, 2'd2);
        tick(); res_valid = 0;
        checks++;
        if (flush !== 0 || strobe !== 0 || bcnt !== 1 || mcnt !== 0) begin
            errors++; $display("FAIL correct_accept: flush=%b strobe=%b bcnt=%0d mcnt=%0d want 0 0 1 0", flush, strobe, bcnt, mcnt);
        end
        tick();
        checks++;
        if (strobe !== 1 || pc_o !== 64'h100 || tgt_o !== 64'h200 || way_o !== 2'd2 || taken_o !== 1 || flush !== 0) begin
            errors++; $display("FAIL correct_update: strobe=%b pc=%h tgt=%h way=%0d tk=%b want 1 100 200 2 1", strobe, pc_o, tgt_o, way_o, taken_o);
        end
        tick();
        checks++;
        if (strobe !== 0) begin errors++; $display("FAIL correct_single_strobe: got %b want 0", strobe); end
    endtask

    task automatic test_nt_mispred();
        do_reset();
        drive(1, 64'h40, 64'h80, 0, 1, 64'h80, 2'd1);
        tick(); res_valid = 0;
        checks++;
        if (flush !== 1 || redirect !== 64'h44 || ready !== 0 || mcnt !== 1) begin
            errors++; $display("FAIL nt_flush: flush=%b redir=%h ready=%b mcnt=%0d want 1 44 0 1", flush, redirect, ready, mcnt);
        end
        tick();
        checks++;
        if (flush !== 0 || ready !== 0 || strobe !== 1 || pc_o !== 64'h40 || taken_o !== 0) begin
            errors++; $display("FAIL nt_second: flush=%b ready=%b strobe=%b pc=%h tk=%b want 0 0 1 40 0", flush, ready, strobe, pc_o, taken_o);
        end
        tick();
        checks++;
        if (ready !== 1) begin errors++; $display("FAIL nt_ready_back: got %b want 1", ready); end
    endtask

    task automatic test_target_mismatch();
        do_reset();
        drive(1, 64'h500, 64'h380, 1, 1, 64'h300, 2'd0);
        tick(); res_valid = 0;
        checks++;
        if (flush !== 1 || redirect !== 64'h380) begin
            errors++; $display("FAIL tgt_flush: flush=%b redir=%h want 1 380", flush, redirect);
        end
        tick(); tick();
        drive(1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 0, 1, 64'h1000, 2'd3);
        tick(); res_valid = 0;
        checks++;
        if (flush !== 1 || redirect !== 64'h0 || mcnt !== 2) begin
            errors++; $display("FAIL wrap_redirect: flush=%b redir=%h mcnt=%0d want 1 0 2", flush, redirect, mcnt);
        end
        tick(); tick();
    endtask

    task automatic test_hold();
        do_reset();
        bpu_hold = 1;
        drive(1, 64'h1000, 64'h9000, 1, 1, 64'h9000, 2'd1);
        tick();
        checks++;
        if (ready !== 1 || strobe !== 0) begin errors++; $display("FAIL hold_first: ready=%b strobe=%b want 1 0", ready, strobe); end
        drive(1, 64'h1004, 64'h9004, 1, 1, 64'h9004, 2'd2);
        tick();
        drive(1, 64'h1008, 64'h9008, 1, 1, 64'h9008, 2'd3);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ready !== 0 || strobe !== 0) begin errors++; $display("FAIL hold_stall%0d: ready=%b strobe=%b want 0 0", i, ready, strobe); end
            if (i < 3) tick();
        end
        bpu_hold = 0;
        tick();
        checks++;
        if (strobe !== 1 || pc_o !== 64'h1000 || ready !== 1 || bcnt !== 2) begin
            errors++; $display("FAIL hold_rel1: strobe=%b pc=%h ready=%b bcnt=%0d want 1 1000 1 2", strobe, pc_o, ready, bcnt);
        end
        tick(); res_valid = 0;
        checks++;
        if (strobe !== 1 || pc_o !== 64'h1004 || way_o !== 2'd2 || bcnt !== 3) begin
            errors++; $display("FAIL hold_rel2: strobe=%b pc=%h way=%0d bcnt=%0d want 1 1004 2 3", strobe, pc_o, way_o, bcnt);
        end
        tick();
        checks++;
        if (strobe !== 1 || pc_o !== 64'h1008) begin
            errors++; $display("FAIL hold_third: strobe=%b pc=%h want 1 1008", strobe, pc_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 64'h2000 + 64'(i) * 8, 64'h3000 + 64'(i) * 16, 1, 1, 64'h3000 + 64'(i) * 16, 2'(i));
            tick();
            checks++;
            if (ready !== 1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, ready); end
            if (i > 0) begin
                checks++;
                if (strobe !== 1 || pc_o !== 64'h2000 + 64'(i - 1) * 8) begin
                    errors++; $display("FAIL b2b_order%0d: strobe=%b pc=%h want 1 %h", i, strobe, pc_o, 64'h2000 + 64'(i - 1) * 8);
                end
            end
        end
        res_valid = 0;
        tick();
        checks++;
        if (strobe !== 1 || pc_o !== 64'h2038 || bcnt !== 8) begin
            errors++; $display("FAIL b2b_last: strobe=%b pc=%h bcnt=%0d want 1 2038 8", strobe, pc_o, bcnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        bpu_hold = 1;
        drive(1, 64'h4000, 64'h5000, 1, 1, 64'h5000, 2'd1);
        tick();
        drive(1, 64'h4100, 64'h5100, 0, 1, 64'h5100, 2'd2);
        tick(); res_valid = 0;
        checks++;
        if (flush !== 1 || ready !== 0) begin errors++; $display("FAIL rmf_setup: flush=%b ready=%b want 1 0", flush, ready); end
        #2 arst = 0;
        #1;
        checks++;
        if ({flush, redirect, strobe, taken_o, pc_o, tgt_o, way_o, bcnt, mcnt} !== '0) begin
            errors++; $display("FAIL rmf_clear: flush=%b redir=%h pc=%h bcnt=%0d mcnt=%0d want all 0", flush, redirect, pc_o, bcnt, mcnt);
        end
        tick();
        arst = 1; bpu_hold = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (strobe !== 0 || ready !== 1) begin errors++; $display("FAIL rmf_stale%0d: strobe=%b ready=%b want 0 1", i, strobe, ready); end
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1, 64'h6000 + 64'(i) * 4, 64'h7000, 1, 1, 64'h7000, 2'd0);
            tick();
        end
        res_valid = 0;
        tick(); tick();
        checks++;
        if (s_bcnt !== 4'd15 || bcnt !== 17 || s_mcnt !== 0) begin
            errors++; $display("FAIL sat_branch: small=%0d big=%0d smis=%0d want 15 17 0", s_bcnt, bcnt, s_mcnt);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1, 64'h8000 + 64'(i) * 4, 64'h7000, 1, 0, 64'h7000, 2'd1);
            tick(); res_valid = 0;
            tick(); tick();
        end
        checks++;
        if (s_mcnt !== 4'd15 || mcnt !== 16 || s_bcnt !== 4'd15 || bcnt !== 33) begin
            errors++; $display("FAIL sat_mispred: smis=%0d mis=%0d sbr=%0d br=%0d want 15 16 15 33", s_mcnt, mcnt, s_bcnt, bcnt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            res_valid  = ($urandom_range(0, 9) < 7);
            res_pc     = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom} & ~64'h3;
            res_tgt    = {$urandom, $urandom} & ~64'h3;
            res_taken  = 1'($urandom);
            res_ptaken = ($urandom_range(0, 9) < 7) ? res_taken : !res_taken;
            res_ptgt   = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} & ~64'h3) : res_tgt;
            res_way    = 2'($urandom);
            bpu_hold   = ($urandom_range(0, 3) == 0);
            tick();
            checks++;
            if (ready !== m_ready() || flush !== m_flush || (m_flush && redirect !== m_redirect)) begin
                errors++; $display("FAIL rnd_ctrl@%0d: ready=%b/%b flush=%b/%b redir=%h/%h", c, ready, m_ready(), flush, m_flush, redirect, m_redirect);
            end
            checks++;
            if (strobe !== m_strobe || pc_o !== m_upd.pc || tgt_o !== m_upd.tgt || taken_o !== m_upd.tk || way_o !== m_upd.way) begin
                errors++; $display("FAIL rnd_update@%0d: strobe=%b/%b pc=%h/%h tgt=%h/%h", c, strobe, m_strobe, pc_o, m_upd.pc, tgt_o, m_upd.tgt);
            end
            checks++;
            if (bcnt !== m_bcnt || mcnt !== m_mcnt || s_bcnt !== m_sb || s_mcnt !== m_sm) begin
                errors++; $display("FAIL rnd_counts@%0d: br=%0d/%0d mis=%0d/%0d sbr=%0d/%0d smis=%0d/%0d", c, bcnt, m_bcnt, mcnt, m_mcnt, s_bcnt, m_sb, s_mcnt, m_sm);
            end
        end
        res_valid = 0;
        bpu_hold  = 0;
    endtask

    initial begin
        arst = 0; bpu_hold = 0;
        drive(0, '0, '0, 0, 0, '0, 2'd0);
        test_reset();
        test_correct();
        test_nt_mispred();
        test_target_mismatch();
        test_hold();
        test_back_to_back();
        test_reset_mid_flush();
        test_saturate();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
